// File: rtl/upscale_line_scheduler_if.sv
// Frame-buffer read port of the upscale line scheduler: a request/ack handshake
// naming a source line, followed by a valid-qualified stream of RGB444 pixels.
interface upscale_line_scheduler_if;
    logic        req;
    logic [7:0]  req_line;
    logic        ack;
    logic        valid;
    logic [11:0] data;

    modport master (output req, req_line, input ack, valid, data);
    modport slave  (input req, req_line, output ack, valid, data);
endinterface

// File: rtl/upscale_line_scheduler.sv
// Fetches QVGA source lines into a 3-bank rotating line buffer and publishes per-display-line
// bank selects for the 2x vertical interpolator. Define UPSCALE_SCHED_STATS_EN for underrun_count.
module upscale_line_scheduler #(
    parameter int SRC_W    = 320,
    parameter int SRC_H    = 240,
    parameter int V_ACTIVE = 480
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic [9:0]  disp_line,
    upscale_line_scheduler_if.master fb,
    output logic        wr_en,
    output logic [1:0]  wr_bank,
    output logic [8:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic [1:0]  top_bank,
    output logic [1:0]  bot_bank,
    output logic        y_frac,
    output logic        busy,
    output logic        underrun,
    output logic        underrun_sticky
`ifdef UPSCALE_SCHED_STATS_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, WAIT} state_t;

    state_t      state;
    logic        mode;
    logic [7:0]  next_src;
    logic [1:0]  src_bank;
    logic [8:0]  lines_loaded;
    logic [8:0]  beat;
    logic        pending;
    logic        req_q;
    logic [7:0]  req_line_q;

    logic        active_line;
    logic        short_line;
    logic        fetch_ask;
    logic        last_beat;
    logic [7:0]  n;
    logic [8:0]  n_plus2;
    logic [8:0]  need;
    logic [1:0]  n_bank;
    logic [1:0]  n_bank_inc;
    logic [7:0]  src_inc;
    logic [1:0]  src_bank_inc;

    // 4 == 1 (mod 3), so the base-4 digit sum preserves the residue; two folds reach 0..6.
    function automatic logic [1:0] mod3(input logic [7:0] v);
        logic [3:0] s;
        logic [2:0] t;
        s = 4'(v[1:0]) + 4'(v[3:2]) + 4'(v[5:4]) + 4'(v[7:6]);
        t = 3'(s[1:0]) + 3'(s[3:2]);
        if (t >= 3'd6)      return 2'(t - 3'd6);
        else if (t >= 3'd3) return 2'(t - 3'd3);
        else                return t[1:0];
    endfunction

    assign active_line  = line_start && !frame_start && mode && (disp_line < 10'(V_ACTIVE));
    assign n            = disp_line[8:1];
    assign n_plus2      = {1'b0, n} + 9'd2;
    assign need         = (n_plus2 < 9'(SRC_H)) ? n_plus2 : 9'(SRC_H);
    assign short_line   = active_line && (lines_loaded < need);
    assign fetch_ask    = active_line && !disp_line[0] && (n_plus2 <= 9'(SRC_H - 1));
    assign n_bank       = mod3(n);
    assign n_bank_inc   = (n_bank == 2'd2) ? 2'd0 : n_bank + 2'd1;
    assign src_inc      = next_src + 8'd1;
    assign src_bank_inc = (src_bank == 2'd2) ? 2'd0 : src_bank + 2'd1;
    assign last_beat    = (state == FILL) && fb.valid && (beat == 9'(SRC_W - 1));

    // Write path is a zero-latency pass-through; frame_start kills it in the abort cycle.
    assign wr_en        = (state == FILL) && fb.valid && !frame_start;
    assign wr_bank      = wr_en ? src_bank : 2'd0;
    assign wr_addr      = wr_en ? beat : 9'd0;
    assign wr_data      = wr_en ? fb.data : 12'd0;
    assign busy         = (state == REQ) || (state == FILL);
    assign fb.req       = req_q;
    assign fb.req_line  = req_line_q;

    // NOTE: sequential state uses non-blocking assignments only; where two assignments to the
    // same register can fire in one cycle (pending), the later one in program order wins.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            mode            <= 1'b0;
            next_src        <= '0;
            src_bank        <= '0;
            lines_loaded    <= '0;
            beat            <= '0;
            pending         <= 1'b0;
            req_q           <= 1'b0;
            req_line_q      <= '0;
            top_bank        <= '0;
            bot_bank        <= '0;
            y_frac          <= 1'b0;
            underrun        <= 1'b0;
            underrun_sticky <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_start) begin
                mode            <= enable;
                pending         <= 1'b0;
                underrun_sticky <= 1'b0;
                req_q           <= enable;
                req_line_q      <= '0;
                next_src        <= '0;
                src_bank        <= '0;
                lines_loaded    <= '0;
                beat            <= '0;
                state           <= enable ? REQ : IDLE;
            end else begin
                if (active_line) begin
                    top_bank <= n_bank;
                    bot_bank <= (n == 8'(SRC_H - 1)) ? n_bank : n_bank_inc;
                    y_frac   <= disp_line[0];
                end
                if (short_line) begin
                    underrun        <= 1'b1;
                    underrun_sticky <= 1'b1;
                end
                unique case (state)
                    IDLE: ;
                    REQ: begin
                        if (fetch_ask) pending <= 1'b1;
                        if (fb.ack) begin
                            req_q <= 1'b0;
                            beat  <= '0;
                            state <= FILL;
                        end
                    end
                    FILL: begin
                        if (fetch_ask) pending <= 1'b1;
                        if (fb.valid) beat <= beat + 9'd1;
                        if (last_beat) begin
                            beat         <= '0;
                            lines_loaded <= lines_loaded + 9'd1;
                            next_src     <= src_inc;
                            src_bank     <= src_bank_inc;
                            pending      <= 1'b0;
                            // Priming needs two lines; a request that arrived mid-fill is served now.
                            if ((lines_loaded == 9'd0 || pending || fetch_ask) && src_inc < 8'(SRC_H)) begin
                                state      <= REQ;
                                req_q      <= 1'b1;
                                req_line_q <= src_inc;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (fetch_ask && next_src < 8'(SRC_H)) begin
                            state      <= REQ;
                            req_q      <= 1'b1;
                            req_line_q <= next_src;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef UPSCALE_SCHED_STATS_EN
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)
            underrun_count <= '0;
        else if (short_line && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_upscale_line_scheduler.sv
// Directed bench for upscale_line_scheduler: table of display-line vectors plus hand sequences
// for priming, underrun, stalled fill with pending request, abort and async reset.
module tb_upscale_line_scheduler;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic        line_start;
    logic [9:0]  disp_line;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [8:0]  wr_addr;
    logic [11:0] wr_data;
    logic [1:0]  top_bank;
    logic [1:0]  bot_bank;
    logic        y_frac;
    logic        busy;
    logic        underrun;
    logic        underrun_sticky;
`ifdef UPSCALE_SCHED_STATS_EN
    logic [15:0] underrun_count;
`endif

    int applied     = 0;
    int miscompares = 0;

    upscale_line_scheduler_if fb ();

    upscale_line_scheduler dut (
        .vga_clk         (vga_clk),
        .reset           (reset),
        .enable          (enable),
        .frame_start     (frame_start),
        .line_start      (line_start),
        .disp_line       (disp_line),
        .fb              (fb),
        .wr_en           (wr_en),
        .wr_bank         (wr_bank),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .top_bank        (top_bank),
        .bot_bank        (bot_bank),
        .y_frac          (y_frac),
        .busy            (busy),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
`ifdef UPSCALE_SCHED_STATS_EN
        ,
        .underrun_count  (underrun_count)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0] disp;
        logic [1:0] top;
        logic [1:0] bot;
        logic       yf;
        logic       und;
        logic       fetch;
        int         line;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fb"},    {23'd0, fb.req, fb.req_line}, 32'd0);
        check({tag, "_wr"},    {8'd0, wr_en, wr_bank, wr_addr, wr_data}, 32'd0);
        check({tag, "_sel"},   {27'd0, top_bank, bot_bank, y_frac}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy, underrun, underrun_sticky}, 32'd0);
`ifdef UPSCALE_SCHED_STATS_EN
        check({tag, "_count"}, {16'd0, underrun_count}, 32'd0);
`endif
    endtask

    task automatic start_frame(input logic en);
        @(posedge vga_clk); #1;
        enable      = en;
        frame_start = 1'b1;
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic pulse_line(input int d);
        @(posedge vga_clk); #1;
        line_start = 1'b1;
        disp_line  = 10'(d);
        @(posedge vga_clk); #1;
        line_start = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge vga_clk); #1;
        reset = 1'b1;
        @(posedge vga_clk); #1;
        reset = 1'b0;
    endtask

    // Frame-buffer side: waits for a request, acks after ack_dly cycles, optional stall,
    // then streams nbeats pixels (pat 1 inserts an idle cycle before every beat).
    task automatic serve(input int line, input int ack_dly, input int pat, input int stall, input int nbeats);
        int          waited;
        logic [2:0]  l3;
        logic [8:0]  b9;
        logic [11:0] d;
        waited = 0;
        l3     = 3'(line);
        @(negedge vga_clk);
        while (!fb.req && waited < 50) begin
            @(negedge vga_clk);
            waited++;
        end
        check("req_seen", {31'd0, fb.req}, 32'd1);
        check("req_line", {24'd0, fb.req_line}, 32'(line));
        check("busy_req", {31'd0, busy}, 32'd1);
        repeat (ack_dly) @(posedge vga_clk);
        #1;
        check("req_hold", {23'd0, fb.req, fb.req_line}, {23'd0, 1'b1, 8'(line)});
        fb.ack = 1'b1;
        @(posedge vga_clk); #1;
        fb.ack = 1'b0;
        check("req_drop", {31'd0, fb.req}, 32'd0);
        repeat (stall) begin
            @(posedge vga_clk); #1;
        end
        for (int b = 0; b < nbeats; b++) begin
            if (pat == 1) begin
                fb.valid = 1'b0;
                @(negedge vga_clk);
                check("gap_wr_en", {31'd0, wr_en}, 32'd0);
                @(posedge vga_clk); #1;
            end
            b9       = 9'(b);
            d        = {l3, b9};
            fb.valid = 1'b1;
            fb.data  = d;
            @(negedge vga_clk);
            check("wr_beat", {8'd0, wr_en, wr_bank, wr_addr, wr_data},
                  {8'd0, 1'b1, 2'(line % 3), b9, d});
            @(posedge vga_clk); #1;
        end
        fb.valid = 1'b0;
        fb.data  = '0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        disp_line   = '0;
        fb.ack      = 1'b0;
        fb.valid    = 1'b0;
        fb.data     = '0;

        //          disp     top   bot   yf    und   fetch line
        vecs[0] = '{10'd0,   2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2};
        vecs[1] = '{10'd1,   2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{10'd2,   2'd1, 2'd2, 1'b0, 1'b0, 1'b1, 3};
        vecs[3] = '{10'd3,   2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{10'd4,   2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 4};
        vecs[5] = '{10'd476, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 0};
        vecs[6] = '{10'd477, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 0};
        vecs[7] = '{10'd478, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 0};
        vecs[8] = '{10'd479, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, 0};
        vecs[9] = '{10'd480, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 0};

        repeat (3) @(posedge vga_clk);
        #1 reset = 1'b0;
        @(negedge vga_clk);
        check_all_zero("reset");

        // Disabled mode: frame_start and line_start leave the block idle.
        start_frame(1'b0);
        pulse_line(5);
        @(negedge vga_clk);
        check("dis_idle", {30'd0, busy, fb.req}, 32'd0);
        check("dis_sel", {27'd0, top_bank, bot_bank, y_frac}, 32'd0);

        // Priming.
        start_frame(1'b1);
        serve(0, 3, 0, 0, 320);
        serve(1, 3, 0, 0, 320);
        @(negedge vga_clk);
        check("prime_idle", {30'd0, busy, fb.req}, 32'd0);
        check("prime_und", {30'd0, underrun, underrun_sticky}, 32'd0);

        // Steady state and bottom edge.
        for (int i = 0; i < 10; i++) begin
            pulse_line(int'(vecs[i].disp));
            @(negedge vga_clk);
            check("tbl_sel", {27'd0, top_bank, bot_bank, y_frac},
                  {27'd0, vecs[i].top, vecs[i].bot, vecs[i].yf});
            check("tbl_underrun", {31'd0, underrun}, {31'd0, vecs[i].und});
            check("tbl_fetch", {31'd0, fb.req}, {31'd0, vecs[i].fetch});
            if (vecs[i].fetch) begin
                serve(vecs[i].line, 1, 0, 0, 320);
                @(negedge vga_clk);
                check("tbl_done", {31'd0, busy}, 32'd0);
            end
        end
        check("tbl_sticky", {31'd0, underrun_sticky}, 32'd1);
`ifdef UPSCALE_SCHED_STATS_EN
        check("tbl_count", {16'd0, underrun_count}, 32'd4);
`endif

        // Underrun: line-2 fill stalled past disp_line 2.
        apply_reset();
        @(negedge vga_clk);
        check("rst2_sticky", {31'd0, underrun_sticky}, 32'd0);
`ifdef UPSCALE_SCHED_STATS_EN
        check("rst2_count", {16'd0, underrun_count}, 32'd0);
`endif
        start_frame(1'b1);
        serve(0, 1, 0, 0, 320);
        serve(1, 1, 0, 0, 320);
        pulse_line(0);
        @(negedge vga_clk);
        check("u_fetch2", {30'd0, fb.req, underrun}, 32'd2);
        fork
            serve(2, 1, 0, 20, 320);
            begin
                repeat (3) @(posedge vga_clk);
                pulse_line(1);
                @(negedge vga_clk);
                check("u_line1", {31'd0, underrun}, 32'd0);
                pulse_line(2);
                @(negedge vga_clk);
                check("u_pulse", {30'd0, underrun, underrun_sticky}, 32'd3);
                check("u_sel", {27'd0, top_bank, bot_bank, y_frac}, {27'd0, 2'd1, 2'd2, 1'b0});
                @(negedge vga_clk);
                check("u_once", {30'd0, underrun, underrun_sticky}, 32'd1);
            end
        join
        @(negedge vga_clk);
        check("u_pend_req", {23'd0, fb.req, fb.req_line}, {23'd0, 1'b1, 8'd3});
`ifdef UPSCALE_SCHED_STATS_EN
        check("u_count", {16'd0, underrun_count}, 32'd1);
`endif
        serve(3, 1, 0, 0, 320);

        // Stalled fill (alternating valid) with the next even line arriving mid-fill.
        pulse_line(3);
        @(negedge vga_clk);
        check("s_line3", {30'd0, fb.req, underrun}, 32'd0);
        pulse_line(4);
        @(negedge vga_clk);
        check("s_line4", {25'd0, fb.req, underrun, top_bank, bot_bank, y_frac},
              {25'd0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0});
        fork
            serve(4, 0, 1, 0, 320);
            begin
                repeat (40) @(posedge vga_clk);
                pulse_line(5);
                @(negedge vga_clk);
                check("s_line5", {31'd0, underrun}, 32'd0);
                pulse_line(6);
                @(negedge vga_clk);
                check("s_line6", {26'd0, underrun, top_bank, bot_bank, y_frac},
                      {26'd0, 1'b1, 2'd0, 2'd1, 1'b0});
            end
        join
        @(negedge vga_clk);
        check("s_pend_req", {23'd0, fb.req, fb.req_line}, {23'd0, 1'b1, 8'd5});
`ifdef UPSCALE_SCHED_STATS_EN
        check("s_count", {16'd0, underrun_count}, 32'd2);
`endif
        serve(5, 0, 0, 0, 320);

        // Abort by frame_start in the middle of a fill.
        pulse_line(7);
        pulse_line(8);
        @(negedge vga_clk);
        check("a_line8", {25'd0, fb.req, underrun, top_bank, bot_bank, y_frac},
              {25'd0, 1'b1, 1'b0, 2'd1, 2'd2, 1'b0});
        serve(6, 1, 0, 0, 100);
        enable      = 1'b1;
        frame_start = 1'b1;
        fb.valid    = 1'b1;
        fb.data     = 12'hABC;
        @(negedge vga_clk);
        check("a_wr_kill", {31'd0, wr_en}, 32'd0);
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
        fb.valid    = 1'b0;
        @(negedge vga_clk);
        check("a_restart", {22'd0, busy, underrun_sticky, fb.req, fb.req_line},
              {22'd0, 1'b1, 1'b0, 1'b1, 8'd0});
        check("a_sel_hold", {27'd0, top_bank, bot_bank, y_frac}, {27'd0, 2'd1, 2'd2, 1'b0});

        // Asynchronous reset in the middle of a fill.
        serve(0, 1, 0, 0, 50);
        fb.valid = 1'b1;
        fb.data  = 12'h5A5;
        @(negedge vga_clk);
        check("r_pre", {22'd0, wr_en, wr_addr}, {22'd0, 1'b1, 9'd50});
        #2 reset = 1'b1;
        #1;
        check_all_zero("async");
        fb.valid = 1'b0;
        @(posedge vga_clk); #1;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/upscale_line_scheduler.md
Name: upscale_line_scheduler

Overview:
Sequences source-line fetches for the 2x bilinear upscaler in VGA_SIZE mode. It pulls 320x240 QVGA lines from the frame-buffer read port over a req/ack plus valid-stream interface and writes them into a 3-bank rotating line buffer. For every 640x480 display line it publishes the top/bottom bank selects and the vertical-fraction flag the interpolator consumes. It sits between the frame-buffer reader and the upscaler line buffers, clocked by vga_clk.

Parameters:
SRC_W, 320, source pixels per line
SRC_H, 240, source lines per frame
V_ACTIVE, 480, active display lines (must equal 2*SRC_H)

Ports:
vga_clk  input  1  pixel clock
reset  input  1  asynchronous, active-high
enable  input  1  upscale mode (VGA_SIZE); sampled only on frame_start
frame_start  input  1  1-cycle pulse at start of vertical blanking
line_start  input  1  1-cycle pulse at start of every display line, active and blanking
disp_line  input  10  vertical counter; valid on line_start
fb_req  output  1  fetch request
fb_req_line  output  8  source line requested
fb_ack  input  1  request accepted
fb_valid  input  1  pixel beat valid
fb_data  input  12  RGB444 pixel
wr_en  output  1  line-buffer write strobe
wr_bank  output  2  bank 0..2
wr_addr  output  9  pixel index 0..SRC_W-1
wr_data  output  12  pixel
top_bank  output  2  bank holding source line n
bot_bank  output  2  bank holding line n+1, clamped at bottom edge
y_frac  output  1  disp_line[0] of current active line
busy  output  1  state != IDLE/WAIT
underrun  output  1  1-cycle pulse on a missing line
underrun_sticky  output  1  set by underrun, cleared on frame_start

Behaviour:
- Reset (async): state IDLE; every output 0; lines_loaded=0; pending=0; mode latch=0.
- Mapping: source line k lives in bank k mod 3. Track it with mod-3 counters; no divider.
- States: IDLE, REQ, FILL, WAIT.
- IDLE: on frame_start with enable=1, latch mode, set next_src=0 and lines_loaded=0, go to REQ (priming). With enable=0, stay in IDLE; selects hold 0.
- REQ: fb_req=1, fb_req_line=next_src, both held stable until fb_ack. The fb_ack cycle drops fb_req, clears the beat counter, and moves to FILL. fb_ack while fb_req=0 is ignored.
- FILL: each fb_valid beat drives wr_en=1, wr_bank=next_src mod 3, wr_addr=beat count, wr_data=fb_data, all combinational from fb_valid/fb_data, 0-cycle latency. Gaps in fb_valid hold the counter.
- On beat SRC_W-1: lines_loaded++, next_src++. Then go to REQ if lines_loaded<2 or pending=1, otherwise WAIT.
- WAIT: line_start with disp_line<V_ACTIVE and disp_line even (n=disp_line>>1) requests line n+2 if n+2<=SRC_H-1. This means REQ if idle, or sets pending if still in REQ/FILL.
- Selects: registered on every active line_start, one cycle after the pulse, stable for the line. top_bank=n mod 3. bot_bank=(n+1) mod 3, except n=SRC_H-1 gives bot_bank=top_bank. y_frac=disp_line[0].
- Underrun: on active line_start, lines_loaded<min(n+2,SRC_H) produces a 1-cycle underrun pulse on the next cycle and sets underrun_sticky. Selects still update; the fetch still completes (no skip).
- frame_start while busy: immediate abort. fb_req drops without ack, wr_en=0, pending cleared, priming restarts at line 0. The frame-buffer side discards any in-flight request.
- Simultaneous frame_start and line_start: frame_start wins.
- Blanking lines (disp_line>=V_ACTIVE): no requests, selects hold.

Optional Feature:
UPSCALE_SCHED_STATS_EN: when defined, adds output underrun_count[15:0], which increments on each underrun pulse, saturates at 0xFFFF, and clears only on reset. Without the macro, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Prime: enable=1, frame_start, fb_ack 3 cycles after fb_req, 320 contiguous beats per line -> fb_req_line 0 then 1; wr_bank 0 then 1; wr_addr 0..319 each; busy=0 afterwards; underrun stays 0.
- Steady state: line_start for disp_line 0, 1, 2 -> line 0: top=0, bot=1, y_frac=0, fetch line 2 into bank 2. Line 1: top=0, bot=1, y_frac=1, no request. Line 2: top=1, bot=2, fetch line 3 into bank 0.
- Bottom edge: disp_line 476 -> no fetch of 240. Disp_line 478/479 -> top=bot=2, y_frac=0/1.
- Underrun: hold fb_valid low during the line-2 fetch past disp_line 2's line_start -> underrun pulses once, sticky=1, underrun_count=1 (macro on). The fill then completes to wr_addr 319.
- Stall plus pending: fb_valid toggling every other cycle, next even line_start arrives mid-FILL -> wr_addr advances only on valid beats. After the fill, fb_req rises immediately for the pending line.
- Reset/abort: async reset mid-FILL -> all outputs 0 within the same cycle. A frame_start mid-FILL instead drops wr_en and restarts fb_req_line=0.
